// File: rtl/ram_left_if.sv
// Sample-port bundle for the left DWT RAM: two read/write ports plus the
// lifting sideband shared with sibling RAM blocks.
interface ram_left_if #(
  parameter int DW = 26,
  parameter int AW = 7
);
  logic [AW-1:0] pix_addr_l;
  logic [DW-1:0] pix_din_l;
  logic          pix_we_l;
  logic [DW-1:0] pix_dout_l;

  logic [AW-1:0] pix_addr_r;
  logic [DW-1:0] pix_din_r;
  logic          pix_we_r;
  logic [DW-1:0] pix_dout_r;

  // Lifting sideband, carried for drop-in compatibility only
  logic [DW-1:0] pix_right;
  logic [DW-1:0] pix_left;
  logic          pix_we_even;
  logic          pix_we_odd;
  logic          pix_p;
  logic          pix_fwd_inv;
  logic          pix_even_odd;
  logic [AW-1:0] pix_addr_odd;
  logic [AW-1:0] pix_addr_even;
  logic [DW-1:0] pix_din_even;
  logic [DW-1:0] pix_din_odd;
  logic [DW-1:0] pix_dout_odd;
  logic [DW-1:0] pix_dout_even;

  modport slave (
    input  pix_addr_l, pix_din_l, pix_we_l,
    input  pix_addr_r, pix_din_r, pix_we_r,
    input  pix_right, pix_left, pix_we_even, pix_we_odd, pix_p,
    input  pix_fwd_inv, pix_even_odd, pix_addr_odd, pix_addr_even,
    input  pix_din_even, pix_din_odd, pix_dout_odd, pix_dout_even,
    output pix_dout_l, pix_dout_r
  );

  modport master (
    output pix_addr_l, pix_din_l, pix_we_l,
    output pix_addr_r, pix_din_r, pix_we_r,
    output pix_right, pix_left, pix_we_even, pix_we_odd, pix_p,
    output pix_fwd_inv, pix_even_odd, pix_addr_odd, pix_addr_even,
    output pix_din_even, pix_din_odd, pix_dout_odd, pix_dout_even,
    input  pix_dout_l, pix_dout_r
  );
endinterface

// File: rtl/ram_left.sv
// 128 x 26 true dual-port "left" sample RAM with registered, read-first outputs.
// Port L wins a same-address write collision; sideband inputs are inert.
module ram_left #(
  parameter int DW = 26,
  parameter int AW = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_left_if.slave  pix
);
  localparam int DEPTH = 1 << AW;

  // Index 0 = port L, index 1 = port R
  logic [AW-1:0] w_addr [2];
  logic [DW-1:0] w_din  [2];
  logic          w_we   [2];
  logic [DW-1:0] r_dout [2];
  logic [DW-1:0] r_mem  [DEPTH];

  assign w_addr[0] = pix.pix_addr_l;
  assign w_din[0]  = pix.pix_din_l;
  assign w_we[0]   = pix.pix_we_l;
  assign w_addr[1] = pix.pix_addr_r;
  assign w_din[1]  = pix.pix_din_r;
  assign w_we[1]   = pix.pix_we_r;

  assign pix.pix_dout_l = r_dout[0];
  assign pix.pix_dout_r = r_dout[1];

  // Memory contents are deliberately left out of the reset branch so they
  // survive reset; writes are naturally blocked while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout[0] <= '0;
      r_dout[1] <= '0;
    end else begin
      r_dout[0] <= r_mem[w_addr[0]];
      r_dout[1] <= r_mem[w_addr[1]];
      if (w_we[1]) r_mem[w_addr[1]] <= w_din[1];
      if (w_we[0]) r_mem[w_addr[0]] <= w_din[0];
    end
  end

  logic w_unused_sideband;
  assign w_unused_sideband = ^{pix.pix_right, pix.pix_left, pix.pix_we_even,
                               pix.pix_we_odd, pix.pix_p, pix.pix_fwd_inv,
                               pix.pix_even_odd, pix.pix_addr_odd,
                               pix.pix_addr_even, pix.pix_din_even,
                               pix.pix_din_odd, pix.pix_dout_odd,
                               pix.pix_dout_even};
endmodule

// File: tb/tb_ram_left.sv
// Randomized and directed checks of ram_left against an array model of the
// dual-port RAM: read-first, L-wins collision, reset behaviour, inert sideband.
module tb_ram_left;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_left_if bus ();
  ram_left dut (.clk(clk), .rst_n(rst_n), .pix(bus.slave));

  int n_vec = 0;
  int n_bad = 0;
  logic [25:0] mdl [128];
  logic [25:0] last_l, last_r;

  localparam int SEQ_N = 40;
  logic        seq_we_l [SEQ_N], seq_we_r [SEQ_N];
  logic [6:0]  seq_a_l  [SEQ_N], seq_a_r  [SEQ_N];
  logic [25:0] seq_d_l  [SEQ_N], seq_d_r  [SEQ_N];
  logic [25:0] ref_l    [SEQ_N], ref_r    [SEQ_N];

  task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we_l, input logic [6:0] a_l, input logic [25:0] d_l,
                       input logic we_r, input logic [6:0] a_r, input logic [25:0] d_r,
                       input bit sb);
    bus.pix_we_l = we_l; bus.pix_addr_l = a_l; bus.pix_din_l = d_l;
    bus.pix_we_r = we_r; bus.pix_addr_r = a_r; bus.pix_din_r = d_r;
    bus.pix_right     = sb ? 26'($urandom) : '0;
    bus.pix_left      = sb ? 26'($urandom) : '0;
    bus.pix_we_even   = sb ? 1'($urandom)  : '0;
    bus.pix_we_odd    = sb ? 1'($urandom)  : '0;
    bus.pix_p         = sb ? 1'($urandom)  : '0;
    bus.pix_fwd_inv   = sb ? 1'($urandom)  : '0;
    bus.pix_even_odd  = sb ? 1'($urandom)  : '0;
    bus.pix_addr_odd  = sb ? 7'($urandom)  : '0;
    bus.pix_addr_even = sb ? 7'($urandom)  : '0;
    bus.pix_din_even  = sb ? 26'($urandom) : '0;
    bus.pix_din_odd   = sb ? 26'($urandom) : '0;
    bus.pix_dout_odd  = sb ? 26'($urandom) : '0;
    bus.pix_dout_even = sb ? 26'($urandom) : '0;
  endtask

  // One clock: expected read data is the pre-edge contents (read-first);
  // port L's write lands last so it wins a collision.
  task automatic step(input string tag);
    logic [25:0] exp_l, exp_r;
    exp_l = rst_n ? mdl[bus.pix_addr_l] : 26'd0;
    exp_r = rst_n ? mdl[bus.pix_addr_r] : 26'd0;
    @(posedge clk);
    if (rst_n) begin
      if (bus.pix_we_r) mdl[bus.pix_addr_r] = bus.pix_din_r;
      if (bus.pix_we_l) mdl[bus.pix_addr_l] = bus.pix_din_l;
    end
    #1;
    last_l = bus.pix_dout_l;
    last_r = bus.pix_dout_r;
    chk({tag, "_l"}, bus.pix_dout_l, exp_l);
    chk({tag, "_r"}, bus.pix_dout_r, exp_r);
  endtask

  task automatic run_seq(input bit sb, input bit record);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 7'(i), 26'(i * 32'h00F0F1 + 7), 1'b0, 7'(i), 26'd0, sb);
      step("seq_init");
    end
    for (int i = 0; i < SEQ_N; i++) begin
      drive(seq_we_l[i], seq_a_l[i], seq_d_l[i], seq_we_r[i], seq_a_r[i], seq_d_r[i], sb);
      step("seq");
      if (record) begin
        ref_l[i] = last_l;
        ref_r[i] = last_r;
      end else begin
        chk("sideband_l", last_l, ref_l[i]);
        chk("sideband_r", last_r, ref_r[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 7'd0, 26'd0, 1'b0, 7'd0, 26'd0, 1'b0);
    #1;
    chk("reset_l", bus.pix_dout_l, 26'd0);
    chk("reset_r", bus.pix_dout_r, 26'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill every address so the model is fully defined
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 7'(i), 26'($urandom), 1'b1, 7'(127 - i), 26'($urandom), 1'b0);
      step("fill");
    end
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 7'(i), 26'($urandom), 1'b0, 7'(i), 26'd0, 1'b0);
      step("fill2");
    end

    // Port L write/read
    drive(1'b1, 7'd3, 26'h1234567, 1'b0, 7'd0, 26'd0, 1'b0); step("wr_l3");
    drive(1'b0, 7'd3, 26'd0,       1'b0, 7'd0, 26'd0, 1'b0); step("rd_l3");
    chk("l3_value", bus.pix_dout_l, 26'h1234567);

    // Port R write at top address, both ports read
    drive(1'b0, 7'd0,   26'd0,       1'b1, 7'd127, 26'h3FFFFFF, 1'b0); step("wr_r127");
    drive(1'b0, 7'd127, 26'd0,       1'b0, 7'd127, 26'd0,       1'b0); step("rd_127");
    chk("a127_l", bus.pix_dout_l, 26'h3FFFFFF);
    chk("a127_r", bus.pix_dout_r, 26'h3FFFFFF);

    // Read-first on both ports
    drive(1'b1, 7'd10, 26'h11, 1'b0, 7'd0,  26'd0, 1'b0); step("rf_pre");
    drive(1'b1, 7'd10, 26'h22, 1'b0, 7'd10, 26'd0, 1'b0); step("rf_wr");
    chk("rf_old_l", bus.pix_dout_l, 26'h11);
    chk("rf_old_r", bus.pix_dout_r, 26'h11);
    drive(1'b0, 7'd10, 26'd0, 1'b0, 7'd10, 26'd0, 1'b0); step("rf_rd");
    chk("rf_new_l", bus.pix_dout_l, 26'h22);
    chk("rf_new_r", bus.pix_dout_r, 26'h22);

    // Write collision: L wins
    drive(1'b1, 7'd64, 26'hAAA, 1'b1, 7'd64, 26'hBBB, 1'b0); step("coll_wr");
    drive(1'b0, 7'd64, 26'd0,   1'b0, 7'd64, 26'd0,   1'b0); step("coll_rd");
    chk("coll_l", bus.pix_dout_l, 26'hAAA);
    chk("coll_r", bus.pix_dout_r, 26'hAAA);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 7'($urandom), 26'($urandom),
            1'($urandom), 7'($urandom_range(0, 7) == 0 ? 0 : $urandom), 26'($urandom), 1'b1);
      step("rand");
    end

    // Mid-run asynchronous reset with a write attempt while held
    drive(1'b1, 7'd5, 26'h0ABCDEF, 1'b0, 7'd5, 26'd0, 1'b0); step("pre_rst_wr");
    drive(1'b0, 7'd5, 26'd0,       1'b0, 7'd5, 26'd0, 1'b0); step("pre_rst_rd");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_l", bus.pix_dout_l, 26'd0);
    chk("mid_rst_r", bus.pix_dout_r, 26'd0);
    drive(1'b1, 7'd5, 26'h1555555, 1'b1, 7'd5, 26'h2AAAAAA, 1'b0); step("in_rst");
    rst_n = 1'b1;
    drive(1'b0, 7'd5, 26'd0, 1'b0, 7'd5, 26'd0, 1'b0); step("post_rst");
    chk("retain_l", bus.pix_dout_l, 26'h0ABCDEF);
    chk("retain_r", bus.pix_dout_r, 26'h0ABCDEF);

    // Same sequence with quiet and noisy sideband must match cycle for cycle
    for (int i = 0; i < SEQ_N; i++) begin
      seq_we_l[i] = 1'($urandom); seq_a_l[i] = 7'($urandom_range(0, 15)); seq_d_l[i] = 26'($urandom);
      seq_we_r[i] = 1'($urandom); seq_a_r[i] = 7'($urandom_range(0, 15)); seq_d_r[i] = 26'($urandom);
    end
    run_seq(1'b0, 1'b1);
    run_seq(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
